// File: rtl/stack_arbiter_pkg.sv
// Shared types for the two-requester stack arbiter: FSM state and op encodings.
package stack_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // A push into a full stack or a pop from an empty one is rejected.
  function automatic logic op_illegal(input logic op, input logic full, input logic empty);
    return ((op == OP_PUSH) && full) || ((op == OP_POP) && empty);
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-served flop updated on each decision.
module rr_arb2 (
  input  logic clk,
  input  logic rstN,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  // High when B was served last, so A wins the next tie (also the reset value).
  logic last_b_r;

  // Grant selection: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      gnt_a = last_b_r;
      gnt_b = !last_b_r;
    end else if (req_a) begin
      gnt_a = 1'b1;
    end else if (req_b) begin
      gnt_b = 1'b1;
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Last-served pointer; holds whenever no decision is taken.
  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      last_b_r <= 1'b1;
    end else if (en) begin
      last_b_r <= gnt_b;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates push/pop requests from A and B onto one LIFO stack; all outputs are registered.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         req_a,
  input  logic         op_a,
  input  logic [W-1:0] wdata_a,
  input  logic         req_b,
  input  logic         op_b,
  input  logic [W-1:0] wdata_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         err_a,
  output logic         err_b,
  output logic         rvalid_a,
  output logic         rvalid_b,
  output logic [W-1:0] rdata,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [W-1:0] stk_din,
  input  logic [W-1:0] stk_dout,
  input  logic         stk_full,
  input  logic         stk_empty
);

  state_e         state_r, state_s;
  logic           sel_a_s, sel_b_s, decide_s, op_s, illegal_s;
  logic [W-1:0]   wd_s;
  logic           owner_b_r, owner_b_s, pop_r, pop_s;
  logic           gnt_a_r, gnt_a_s, gnt_b_r, gnt_b_s;
  logic           err_a_r, err_a_s, err_b_r, err_b_s;
  logic           rvalid_a_r, rvalid_a_s, rvalid_b_r, rvalid_b_s;
  logic           stk_push_r, stk_push_s, stk_pop_r, stk_pop_s;
  logic [W-1:0]   stk_din_r, stk_din_s, rdata_r, rdata_s;

  // Requests only count in IDLE; elsewhere req/op/wdata are ignored.
  assign decide_s = (state_r == ST_IDLE) && (req_a || req_b);

  rr_arb2 u_rr (
    .clk   (clk),
    .rstN  (rstN),
    .req_a (req_a && (state_r == ST_IDLE)),
    .req_b (req_b && (state_r == ST_IDLE)),
    .en    (decide_s),
    .gnt_a (sel_a_s),
    .gnt_b (sel_b_s)
  );

  assign op_s      = sel_b_s ? op_b : op_a;
  assign wd_s      = sel_b_s ? wdata_b : wdata_a;
  assign illegal_s = op_illegal(op_s, stk_full, stk_empty);

  // Next-state and next-output logic; every pulse defaults low, data registers hold.
  always_comb begin
    state_s    = state_r;
    owner_b_s  = owner_b_r;
    pop_s      = pop_r;
    gnt_a_s    = 1'b0;
    gnt_b_s    = 1'b0;
    err_a_s    = 1'b0;
    err_b_s    = 1'b0;
    rvalid_a_s = 1'b0;
    rvalid_b_s = 1'b0;
    stk_push_s = 1'b0;
    stk_pop_s  = 1'b0;
    stk_din_s  = stk_din_r;
    rdata_s    = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (decide_s && illegal_s) begin
          err_a_s = sel_a_s;
          err_b_s = sel_b_s;
          state_s = ST_IDLE;
        end else if (decide_s) begin
          gnt_a_s    = sel_a_s;
          gnt_b_s    = sel_b_s;
          stk_push_s = (op_s == OP_PUSH);
          stk_pop_s  = (op_s == OP_POP);
          stk_din_s  = wd_s;
          owner_b_s  = sel_b_s;
          pop_s      = (op_s == OP_POP);
          state_s    = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The stack acts at the end of this cycle; pop data appears one cycle later.
        if (pop_r) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        rdata_s    = stk_dout;
        rvalid_a_s = !owner_b_r;
        rvalid_b_s = owner_b_r;
        state_s    = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      state_r    <= ST_IDLE;
      owner_b_r  <= 1'b0;
      pop_r      <= 1'b0;
      gnt_a_r    <= 1'b0;
      gnt_b_r    <= 1'b0;
      err_a_r    <= 1'b0;
      err_b_r    <= 1'b0;
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      stk_push_r <= 1'b0;
      stk_pop_r  <= 1'b0;
      stk_din_r  <= {W{1'b0}};
      rdata_r    <= {W{1'b0}};
    end else begin
      state_r    <= state_s;
      owner_b_r  <= owner_b_s;
      pop_r      <= pop_s;
      gnt_a_r    <= gnt_a_s;
      gnt_b_r    <= gnt_b_s;
      err_a_r    <= err_a_s;
      err_b_r    <= err_b_s;
      rvalid_a_r <= rvalid_a_s;
      rvalid_b_r <= rvalid_b_s;
      stk_push_r <= stk_push_s;
      stk_pop_r  <= stk_pop_s;
      stk_din_r  <= stk_din_s;
      rdata_r    <= rdata_s;
    end
  end

  assign gnt_a    = gnt_a_r;
  assign gnt_b    = gnt_b_r;
  assign err_a    = err_a_r;
  assign err_b    = err_b_r;
  assign rvalid_a = rvalid_a_r;
  assign rvalid_b = rvalid_b_r;
  assign stk_push = stk_push_r;
  assign stk_pop  = stk_pop_r;
  assign stk_din  = stk_din_r;
  assign rdata    = rdata_r;

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one LIFO stack instance (W-bit data, registered pop output, full/empty flags) between two requesters, A and B.
- Accepts push/pop requests with a level req / pulse gnt handshake and arbitrates round-robin.
- Drives the stack's push/pop/data inputs, rejects illegal operations (push when full, pop when empty) with an error pulse, and returns pop data to the winning requester.
- Sits between the requester logic and the stack; it is the only master of the stack's control inputs.

Parameters:
- W, 4, data width; must equal the stack data width.

Ports:
- clk  in  1  clock, rising edge.
- rstN  in  1  reset, asynchronous, active-high.
- req_a  in  1  requester A request; held high until gnt_a or err_a.
- op_a  in  1  A operation: 0 = push, 1 = pop; stable while req_a is high.
- wdata_a  in  W  A push data; stable while req_a is high.
- req_b, op_b, wdata_b  in  1/1/W  same as A, for requester B.
- gnt_a, gnt_b  out  1  one-cycle pulse: request accepted and issued to the stack.
- err_a, err_b  out  1  one-cycle pulse: request rejected, no stack operation performed.
- rvalid_a, rvalid_b  out  1  one-cycle pulse: rdata holds the popped value for that requester.
- rdata  out  W  pop result; holds its value until the next pop completes.
- stk_push, stk_pop  out  1  stack controls (registered); never both high.
- stk_din  out  W  stack write data (registered).
- stk_dout  in  W  stack pop data; valid the cycle after the pop edge.
- stk_full, stk_empty  in  1  stack flags, 1 = full / 1 = empty.

Behaviour:
- Reset (async, rstN=1): state IDLE; all outputs 0; rr pointer set so A wins the next tie. Reset mid-operation abandons any in-flight op with no gnt/err/rvalid afterwards. The stack shares the same reset.
- FSM states:
  - IDLE: evaluate requests.
    - No request: stay in IDLE.
    - Winner chosen: single requester wins; if both request, the one not served last wins; then update the rr pointer.
    - Illegal op (push && stk_full, or pop && stk_empty): pulse err_x next cycle, stay in IDLE.
    - Legal op: next cycle gnt_x=1, stk_push or stk_pop=1, stk_din=wdata_x, go to ISSUE.
  - ISSUE: stk_push/stk_pop high this cycle only; the stack acts at the closing edge. A push goes to IDLE; a pop goes to WAIT.
  - WAIT: stk_dout valid; at the edge rdata<=stk_dout, rvalid_x pulses next cycle; go to IDLE.
- Latency, from the IDLE cycle where the winning request is sampled:
  - push: gnt at +1, stack updated at end of +1; next decision at +2.
  - pop: gnt at +1, rvalid/rdata at +3; next decision at +3.
  - error: err at +1; next decision at +1.
- Flags are sampled only in IDLE, when no operation is in flight, so they are always current.
- Rejected requests consume the arbitration turn: the pointer updates exactly as for a grant.
- Requesters deassert req the cycle after gnt/err. A req still high in IDLE is treated as a new request.
- req/op/wdata are ignored outside IDLE; a requester drops req only after gnt/err.
- stk_push and stk_pop are never both high; at most one stack op per ISSUE cycle.
- The pointer holds across idle cycles.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, WAIT), op encoding constants (OP_PUSH=0, OP_POP=1).
- One natural sub-module, rr_arb2: 2-way round-robin arbiter (combinational grant plus last-served flop, enable = decision taken).

Test Plan (stack depth 7, W=4):
- Reset, A pushes 4'h5 -> gnt_a at +1, stk_push one cycle with stk_din=5, stk_empty falls; then A pops -> rvalid_a at +3, rdata=4'h5.
- A and B request push together from reset -> A granted first, B granted in its next IDLE decision; stack order B-value on top; two pops return B then A.
- B pops on an empty stack -> err_b one cycle, stk_pop never asserted, rdata unchanged.
- Push 7 values 1..7, then A pushes 4'h8 -> err_a, stk_full stays 1; 7 pops return 7,6,...,1, then stk_empty=1.
- Both requesters continuously pushing/popping -> grants strictly alternate A,B,A,B (including err turns).
- Assert rstN during WAIT of a pop -> all outputs 0 immediately, no rvalid afterwards, first post-reset tie goes to A.
